// File: rtl/scan_select_gen.sv
// scan_select_gen: select-code generator feeding the d/c/b/a inputs of a
// 4-to-16 decoder. In auto-scan it steps the code 0..LAST_CH with a
// programmable dwell per code. In direct mode it takes single codes over a
// valid/ready handshake. strobe marks the first cycle of every new code, and
// wrap marks the LAST_CH -> 0 step of the scan.
//
// Optional build macro: SCAN_GRAY_EN -- when defined, the auto-scan code is
// the Gray encoding of the scan index. Direct-mode codes are never converted.
module scan_select_gen #(
    parameter int DWELL_W = 8,
    parameter int LAST_CH = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               req_valid,
    input  logic [3:0]         req_code,
    output logic               req_ready,
    output logic               d,
    output logic               c,
    output logic               b,
    output logic               a,
    output logic               strobe,
    output logic               wrap,
    output logic               err,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CODE = 4'(LAST_CH);

    state_t             state_reg, state_next;
    logic [3:0]         code_reg, code_next;
    logic [3:0]         idx_reg, idx_next;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;
    logic [DWELL_W-1:0] lim_reg, lim_next;
    logic               strobe_reg, strobe_next;
    logic               wrap_reg, wrap_next;
    logic               err_reg, err_next;

    // Terminal count for the dwell counter; a dwell of 0 behaves like 1.
    logic [DWELL_W-1:0] dwell_lim;
    assign dwell_lim = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

    // Next scan index, wrapping after LAST_CH.
    logic [3:0] idx_adv;
    assign idx_adv = (idx_reg == LAST_CODE) ? 4'd0 : idx_reg + 4'd1;

    // Scan index to decoder code.
    function automatic logic [3:0] scan_map(input logic [3:0] idx);
`ifdef SCAN_GRAY_EN
        return idx ^ (idx >> 1);
`else
        return idx;
`endif
    endfunction

    // Next-state and next-output decode; en has priority over mode,
    // mode changes over dwell expiry and handshakes.
    always_comb begin
        state_next  = state_reg;
        code_next   = code_reg;
        idx_next    = idx_reg;
        cnt_next    = cnt_reg;
        lim_next    = lim_reg;
        strobe_next = 1'b0;
        wrap_next   = 1'b0;
        err_next    = 1'b0;

        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!mode) begin
                        state_next  = SCAN;
                        idx_next    = 4'd0;
                        code_next   = scan_map(4'd0);
                        cnt_next    = '0;
                        lim_next    = dwell_lim;
                        strobe_next = 1'b1;
                    end else begin
                        state_next = HOLD;
                    end
                end
                SCAN: begin
                    if (mode) begin
                        // Freeze on the current code for direct access.
                        state_next = HOLD;
                        cnt_next   = '0;
                    end else if (cnt_reg == lim_reg) begin
                        // Dwell expired: advance and re-sample the dwell.
                        cnt_next    = '0;
                        idx_next    = idx_adv;
                        code_next   = scan_map(idx_adv);
                        lim_next    = dwell_lim;
                        strobe_next = 1'b1;
                        wrap_next   = (idx_reg == LAST_CODE);
                    end else begin
                        cnt_next = cnt_reg + DWELL_W'(1);
                    end
                end
                HOLD: begin
                    if (!mode) begin
                        // Returning to auto-scan always restarts at index 0.
                        state_next  = SCAN;
                        idx_next    = 4'd0;
                        code_next   = scan_map(4'd0);
                        cnt_next    = '0;
                        lim_next    = dwell_lim;
                        strobe_next = 1'b1;
                    end else if (req_valid) begin
                        // req_ready is high throughout HOLD, so valid alone
                        // means a transfer. Out-of-range codes are rejected.
                        if (req_code <= LAST_CODE) begin
                            code_next   = req_code;
                            strobe_next = 1'b1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            code_reg   <= 4'd0;
            idx_reg    <= 4'd0;
            cnt_reg    <= '0;
            lim_reg    <= '0;
            strobe_reg <= 1'b0;
            wrap_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            code_reg   <= code_next;
            idx_reg    <= idx_next;
            cnt_reg    <= cnt_next;
            lim_reg    <= lim_next;
            strobe_reg <= strobe_next;
            wrap_reg   <= wrap_next;
            err_reg    <= err_next;
        end
    end

    assign {d, c, b, a} = code_reg;
    assign strobe       = strobe_reg;
    assign wrap         = wrap_reg;
    assign err          = err_reg;
    assign busy         = (state_reg != IDLE);
    assign req_ready    = (state_reg == HOLD);

endmodule

// File: tb/tb_scan_select_gen.sv
// Bench for scan_select_gen. Two instances share one stimulus stream: one
// built with LAST_CH=15 and one with LAST_CH=9. Each is compared every cycle
// against a behavioural model that tracks cycles left on the current code.
module tb_scan_select_gen;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n, en, mode, req_valid;
    logic [DW-1:0] dwell;
    logic [3:0]    req_code;

    logic rdy0, d0, c0, b0, a0, stb0, wrp0, err0, bsy0;
    logic rdy1, d1, c1, b1, a1, stb1, wrp1, err1, bsy1;

    // 100 MHz style free-running clock.
    always #5 clk = ~clk;

    scan_select_gen #(.DWELL_W(DW), .LAST_CH(15)) u_dut15 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dwell(dwell),
        .req_valid(req_valid), .req_code(req_code), .req_ready(rdy0),
        .d(d0), .c(c0), .b(b0), .a(a0),
        .strobe(stb0), .wrap(wrp0), .err(err0), .busy(bsy0)
    );

    scan_select_gen #(.DWELL_W(DW), .LAST_CH(9)) u_dut9 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .dwell(dwell),
        .req_valid(req_valid), .req_code(req_code), .req_ready(rdy1),
        .d(d1), .c(c1), .b(b1), .a(a1),
        .strobe(stb1), .wrap(wrp1), .err(err1), .busy(bsy1)
    );

    // st: 0 idle, 1 scanning, 2 direct hold
    typedef struct {
        int st;
        int idx;
        int code;
        int left;
        bit strobe;
        bit wrap;
        bit err;
        bit acc;
    } mdl_t;

    mdl_t m[2];
    int   lc[2] = '{15, 9};
    int   vectors = 0;
    int   miscompares = 0;

    function automatic int scan_code(input int i);
`ifdef SCAN_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    function automatic int eff_dwell(input int dw);
        return (dw == 0) ? 1 : dw;
    endfunction

    // Advance model k by one clock edge using the currently applied inputs.
    task automatic model_step(input int k);
        m[k].strobe = 0;
        m[k].wrap   = 0;
        m[k].err    = 0;
        m[k].acc    = 0;
        if (!rst_n) begin
            m[k].st = 0; m[k].idx = 0; m[k].code = 0; m[k].left = 0;
        end else if (!en) begin
            m[k].st = 0;
        end else if (m[k].st == 0 || (m[k].st == 2 && !mode)) begin
            if (!mode || m[k].st == 2) begin
                m[k].st = 1; m[k].idx = 0; m[k].code = scan_code(0);
                m[k].left = eff_dwell(int'(dwell)); m[k].strobe = 1;
            end else begin
                m[k].st = 2;
            end
        end else if (m[k].st == 1) begin
            if (mode) begin
                m[k].st = 2;
            end else begin
                m[k].left--;
                if (m[k].left == 0) begin
                    m[k].wrap   = (m[k].idx == lc[k]);
                    m[k].idx    = m[k].wrap ? 0 : m[k].idx + 1;
                    m[k].code   = scan_code(m[k].idx);
                    m[k].left   = eff_dwell(int'(dwell));
                    m[k].strobe = 1;
                end
            end
        end else if (req_valid) begin
            m[k].acc = 1;
            if (int'(req_code) <= lc[k]) begin
                m[k].code = int'(req_code); m[k].strobe = 1;
            end else begin
                m[k].err = 1;
            end
        end
    endtask

    task automatic check_one(input int k, input logic [8:0] obs);
        logic [8:0] exp;
        exp = {4'(m[k].code), m[k].strobe, m[k].wrap, m[k].err,
               (m[k].st != 0), (m[k].st == 2)};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL last_ch%0d t=%0t {dcba,stb,wrap,err,busy,rdy} observed=%b expected=%b",
                   lc[k], $time, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_one(0, {d0, c0, b0, a0, stb0, wrp0, err0, bsy0, rdy0});
        check_one(1, {d1, c1, b1, a1, stb1, wrp1, err1, bsy1, rdy1});
        if (m[0].acc)
            $display("txn t=%0t req_code=%0d -> code15=%0d err15=%0b code9=%0d err9=%0b",
                     $time, req_code, m[0].code, m[0].err, m[1].code, m[1].err);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m[k].st = 0; m[k].idx = 0; m[k].code = 0; m[k].left = 0;
            m[k].strobe = 0; m[k].wrap = 0; m[k].err = 0; m[k].acc = 0;
        end
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; dwell = DW'(3);
        req_valid = 1'b0; req_code = 4'd0;

        // Reset, then idle with en low.
        run(2);
        rst_n = 1'b1;
        run(20);

        // Full scan with dwell 3 through at least one wrap of each build.
        en = 1'b1; mode = 1'b0; dwell = DW'(3);
        run(60);

        // Dwell 0 and 1: new code every cycle.
        dwell = DW'(0);
        run(20);
        dwell = DW'(1);
        run(5);

        // Dwell changing on random cycles mid-step.
        for (int i = 0; i < 60; i++) begin
            dwell = DW'($urandom_range(0, 4));
            step();
        end

        // Direct mode: freeze, repeat the same code, out-of-range code.
        mode = 1'b1;
        run(3);
        req_valid = 1'b1; req_code = 4'd5;
        step();
        step();
        req_code = 4'd12;
        step();
        req_valid = 1'b0;
        run(2);
        for (int i = 0; i < 30; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_code  = 4'($urandom_range(0, 15));
            step();
        end

        // Back to scan, freeze again, then disable with a request pending.
        req_valid = 1'b0; mode = 1'b0; dwell = DW'(2);
        run(10);
        mode = 1'b1;
        run(2);
        en = 1'b0; req_valid = 1'b1; req_code = 4'd3;
        step();
        req_valid = 1'b0;
        run(3);

        // Single-cycle scan (Gray sequence when that build option is on).
        en = 1'b1; mode = 1'b0; dwell = DW'(1);
        run(20);

        // Reset in the middle of a scan.
        dwell = DW'(2);
        run(15);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; en = 1'b0;
        run(2);

        // Random soak across all controls.
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            en        = ($urandom_range(0, 9) != 0);
            mode      = ($urandom_range(0, 7) == 0) ? ~mode : mode;
            dwell     = DW'($urandom_range(0, 5));
            req_valid = 1'($urandom_range(0, 1));
            req_code  = 4'($urandom_range(0, 15));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scan_select_gen.md
Name: scan_select_gen

Overview:
Sequential select-code generator that sits directly upstream of the 4-to-16 decoder and drives its d, c, b, a inputs.
- Auto-scan mode: steps the 4-bit code 0..LAST_CH with a programmable dwell per code. Used for LED/keypad row multiplexing.
- Direct mode: accepts single codes over a valid/ready handshake.
- Strobe and wrap pulses tell downstream logic when the selected decoder output changes.

Parameters:
DWELL_W, 8, width of dwell input and internal dwell counter
LAST_CH, 15, highest code reached in auto-scan (legal range 1..15); scan wraps to 0 after it

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
en  input  1  block enable; 0 forces IDLE
mode  input  1  0 = auto-scan, 1 = direct (handshake)
dwell  input  DWELL_W  cycles each code is held in auto-scan; 0 treated as 1
req_valid  input  1  direct-mode request valid
req_code  input  4  direct-mode requested code
req_ready  output  1  block accepts req_code this cycle
d  output  1  select bit 3 (MSB) to decoder
c  output  1  select bit 2
b  output  1  select bit 1
a  output  1  select bit 0 (LSB)
strobe  output  1  one-cycle pulse in the first cycle a new code is on {d,c,b,a}
wrap  output  1  one-cycle pulse, coincident with strobe, when auto-scan goes LAST_CH -> 0
err  output  1  one-cycle pulse when a direct request with req_code > LAST_CH is accepted
busy  output  1  high whenever state != IDLE

Behaviour:
- Clocking: all state on rising clk edge. Reset is synchronous: rst_n sampled low at an edge resets everything at that edge.
- Reset values: {d,c,b,a}=4'b0000; strobe=0, wrap=0, err=0, req_ready=0, busy=0; state=IDLE; dwell counter=0; scan index=0.
- Outputs: all registered. {d,c,b,a} = code register. busy and req_ready decode from registered state (req_ready=1 only in HOLD).
- States: IDLE, SCAN, HOLD.
- IDLE:
  - en=0: stay; code holds last value; pulses 0.
  - en=1, mode=0: -> SCAN; index=0, code=0, strobe=1 next cycle, dwell counter cleared, dwell sampled.
  - en=1, mode=1: -> HOLD; code unchanged, no strobe.
- SCAN:
  - Dwell counter increments each cycle.
  - At count == max(dwell,1)-1: counter clears, index advances, strobe=1 in the cycle the new code appears.
  - Dwell is re-sampled at every code change. A dwell change mid-step affects the next step only.
  - Advance from LAST_CH goes to 0, with wrap=1 coincident with strobe.
  - dwell=0 or 1: new code every cycle; strobe continuously high.
- SCAN exits:
  - mode=1: -> HOLD next cycle; current code held; counter cleared; no strobe.
  - en=0: -> IDLE; code held.
- HOLD:
  - req_ready=1.
  - Transfer on req_valid && req_ready.
  - req_code <= LAST_CH: code=req_code next cycle, strobe=1 (even if equal to current code).
  - req_code > LAST_CH: code unchanged, err=1 next cycle, no strobe.
  - req_valid without ready: no effect.
- HOLD exits:
  - mode=0: -> SCAN restarting at index 0 with strobe.
  - en=0: -> IDLE; any request in that cycle is not accepted (req_ready is registered low from the next cycle; same-cycle request is dropped because en=0 has priority).
- Priority per cycle: rst_n > en > mode change > dwell expiry / handshake.
- Reset mid-scan: next cycle code=0, state IDLE, no strobe or wrap.

Optional Feature:
SCAN_GRAY_EN
- Defined: in auto-scan, code output = binary-to-Gray of the scan index (0,1,3,2,6,7,5,4,...), so only one select bit toggles per step. Wrap is still defined on index LAST_CH -> 0. Direct-mode codes pass through unconverted, and the err check applies to the raw req_code.
- Undefined: code = scan index (plain binary).

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then rst_n=1, en=0 -> {d,c,b,a}=0000, busy=0, req_ready=0, no pulses for 20 cycles.
- Full scan: en=1, mode=0, dwell=3 -> codes 0..15 each held exactly 3 cycles; strobe at each change; wrap=1 only on the 15->0 step, 48 cycles after the first strobe.
- Dwell edge and LAST_CH=9: dwell=0 -> code changes every cycle, strobe held high; a separate build with LAST_CH=9 wraps 9->0 with wrap pulse.
- Direct handshake: mode=1, req_valid=1, req_code=5 -> code=0101 next cycle with strobe; req_code=5 again -> strobe again; with LAST_CH=9, req_code=12 -> err=1, code stays 0101.
- Mode/enable switching: mid-scan at code 7, mode=1 -> code stays 0111, req_ready=1; mode=0 -> restart at 0 with strobe; en=0 with req_valid=1 -> request ignored, state IDLE.
- Reset mid-operation / Gray: rst_n=0 at code 11 -> code 0000 next edge, no wrap. With SCAN_GRAY_EN, dwell=1 -> sequence 0000,0001,0011,0010,0110..., exactly one bit changes per step, including 1000->0000 at wrap.
